// File: rtl/vo_rom_reader.sv
// vo_rom_reader: read-side sequencer for the 256x8 vowel/phoneme ROM.
// It walks a contiguous address run and allows for the ROM's one-cycle
// registered read. Returned bytes are buffered in a small FIFO and streamed
// downstream on a valid/ready interface.
module vo_rom_reader #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          CS,
  input  logic          cen,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] length,
  input  logic          abort,
  output logic [AW-1:0] rom_add,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] smp_data,
  output logic          smp_valid,
  input  logic          smp_ready,
  output logic          busy,
  output logic          done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  state_e        state_q;
  logic [AW-1:0] rom_add_q;
  logic [AW-1:0] remaining_q;
  logic          pend_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [DW-1:0] smp_data_q;
  logic          smp_valid_q;
  logic          busy_q;
  logic          done_q;

  logic          credit_s;
  logic          issue_s;
  logic          wr_s;
  logic          rd_s;
  logic [PW-1:0] rd_ptr_d;
  logic [CW-1:0] count_d;
  logic [DW-1:0] head_s;

  // Issue credit, FIFO write/read strobes, next occupancy and next head sample.
  always_comb begin
    credit_s = 1'b0;
    issue_s  = 1'b0;
    wr_s     = 1'b0;
    rd_s     = 1'b0;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_s   = mem_q[rd_ptr_q];

    // Reserve a FIFO slot for the read already in flight so a capture can never overflow.
    credit_s = (count_q + {{(CW-1){1'b0}}, pend_q}) < DEPTH_C;
    issue_s  = (state_q == FETCH) && !abort && (remaining_q != {AW{1'b0}}) && credit_s;
    wr_s     = pend_q && !abort;
    rd_s     = smp_valid_q && smp_ready && !abort;

    if (rd_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_s, rd_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // The byte being written becomes the head when it lands in the slot the read pointer moves to.
    if (wr_s && (rd_ptr_d == wr_ptr_q)) begin
      head_s = rom_data;
    end else begin
      head_s = mem_q[rd_ptr_d];
    end
  end

  // Sequencer FSM, FIFO storage and registered outputs.
  always_ff @(posedge CS or negedge cen) begin
    if (!cen) begin
      state_q     <= IDLE;
      rom_add_q   <= {AW{1'b0}};
      remaining_q <= {AW{1'b0}};
      pend_q      <= 1'b0;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      smp_data_q  <= {DW{1'b0}};
      smp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
    end else if (abort && (state_q != IDLE)) begin
      // Cancel: flush buffered and in-flight data, keep rom_add where it stopped.
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      smp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pend_q   <= issue_s;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      done_q   <= (state_q == FIN);

      if (wr_s) begin
        mem_q[wr_ptr_q] <= rom_data;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end

      smp_valid_q <= (count_d != {CW{1'b0}});
      if (count_d != {CW{1'b0}}) begin
        smp_data_q <= head_s;
      end else begin
        smp_data_q <= smp_data_q;
      end

      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            busy_q <= 1'b1;
            if (length == {AW{1'b0}}) begin
              state_q <= FIN;
            end else begin
              remaining_q <= length;
              rom_add_q   <= start_addr;
              state_q     <= FETCH;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        FETCH: begin
          busy_q <= 1'b1;
          if (issue_s) begin
            rom_add_q   <= rom_add_q + ADDR_ONE;
            remaining_q <= remaining_q - ADDR_ONE;
            if (remaining_q == ADDR_ONE) begin
              state_q <= DRAIN;
            end else begin
              state_q <= FETCH;
            end
          end else begin
            state_q <= FETCH;
          end
        end
        DRAIN: begin
          busy_q <= 1'b1;
          if (!pend_q && (count_q == {CW{1'b0}})) begin
            state_q <= FIN;
          end else begin
            state_q <= DRAIN;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rom_add   = rom_add_q;
  assign smp_data  = smp_data_q;
  assign smp_valid = smp_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vo_rom_reader.sv
// Bench for vo_rom_reader: ROM model (data = addr ^ 0x5A, one-cycle latency),
// a scoreboard queue of expected samples, table-driven runs plus hand
// sequences for latency, wrap, backpressure, empty run, abort and reset.
module tb_vo_rom_reader;

  logic       CS = 1'b0;
  logic       cen;
  logic       start;
  logic [7:0] start_addr;
  logic [7:0] length;
  logic       abort;
  logic [7:0] rom_add;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] smp_data;
  logic       smp_valid;
  logic       smp_ready;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int rx_cnt   = 0;

  logic [7:0] exp_q[$];

  logic       prev_v   = 1'b0;
  logic       prev_r   = 1'b0;
  logic       prev_ab  = 1'b0;
  logic       prev_cen = 1'b0;
  logic [7:0] prev_d   = 8'h00;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] len;
    int         stall;
    logic [7:0] first;
  } vec_t;

  vec_t vecs[6];

  vo_rom_reader #(.AW(8), .DW(8), .DEPTH(4)) dut (
    .CS(CS), .cen(cen), .start(start), .start_addr(start_addr),
    .length(length), .abort(abort), .rom_add(rom_add), .rom_data(rom_data),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .busy(busy), .done(done)
  );

  always #5 CS = ~CS;

  // ROM model: registered read with one-cycle latency
  always @(posedge CS) rom_data <= rom_add ^ 8'h5A;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Output monitor: scoreboard pops, stall stability, done counting, overflow guard
  always @(negedge CS) begin
    if (cen && done) done_cnt++;
    if (cen && prev_cen && prev_v && !prev_r && !prev_ab) begin
      chk("hold_valid", {31'd0, smp_valid}, 32'd1);
      chk("hold_data", {24'd0, smp_data}, {24'd0, prev_d});
    end
    if (cen && smp_valid && smp_ready && !abort) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_sample: got 0x%0h, expected no sample", smp_data);
      end else begin
        chk("sample", {24'd0, smp_data}, {24'd0, exp_q.pop_front()});
        rx_cnt++;
      end
    end
    if (cen && ((int'(dut.count_q) + int'(dut.pend_q)) > 4)) begin
      n_checks++;
      n_fail++;
      $display("FAIL fifo_overflow: got count+pend %0d, expected <= 4",
               int'(dut.count_q) + int'(dut.pend_q));
    end
    prev_v   <= smp_valid;
    prev_r   <= smp_ready;
    prev_ab  <= abort;
    prev_cen <= cen;
    prev_d   <= smp_data;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CS);
    #1;
  endtask

  task automatic start_run(input logic [7:0] a, input logic [7:0] l);
    logic [7:0] ad;
    for (int i = 0; i < int'(l); i++) begin
      ad = a + 8'(i);
      exp_q.push_back(ad ^ 8'h5A);
    end
    start      = 1'b1;
    start_addr = a;
    length     = l;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!busy && exp_q.size() == 0) break;
      tick(1);
    end
    chk("idle_in_budget", {31'd0, (i < budget)}, 32'd1);
    tick(2);
  endtask

  task automatic run_vec(input vec_t v);
    int rx0;
    int d0;
    rx0 = rx_cnt;
    d0  = done_cnt;
    start_run(v.addr, v.len);
    for (int i = 0; i < 10 && !smp_valid; i++) tick(1);
    chk("vec_first_valid", {31'd0, smp_valid}, 32'd1);
    chk("vec_first_data", {24'd0, smp_data}, {24'd0, v.first});
    if (v.stall != 0) begin
      smp_ready = 1'b0;
      tick(v.stall);
      smp_ready = 1'b1;
    end
    wait_idle(600);
    chk("vec_count", rx_cnt - rx0, {24'd0, v.len});
    chk("vec_done", done_cnt - d0, 32'd1);
  endtask

  initial begin
    int d0;
    int rx0;
    int i;

    vecs[0] = '{8'h10, 8'd4,   0, 8'h4A};
    vecs[1] = '{8'hFE, 8'd4,   0, 8'hA4};
    vecs[2] = '{8'h40, 8'd10,  8, 8'h1A};
    vecs[3] = '{8'h00, 8'd2,   0, 8'h5A};
    vecs[4] = '{8'hF0, 8'd20,  3, 8'hAA};
    vecs[5] = '{8'h7F, 8'd255, 0, 8'h25};

    cen = 1'b0; start = 1'b0; start_addr = 8'h00; length = 8'h00;
    abort = 1'b0; smp_ready = 1'b1;
    tick(3);
    chk("rst_rom_add", {24'd0, rom_add}, 32'h0);
    chk("rst_valid", {31'd0, smp_valid}, 32'd0);
    chk("rst_data", {24'd0, smp_data}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    #2 cen = 1'b1;
    tick(2);

    // Basic run with exact latency
    d0 = done_cnt; rx0 = rx_cnt;
    start_run(8'h10, 8'd4);
    chk("lat_rom_add0", {24'd0, rom_add}, 32'h10);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    chk("lat_valid0", {31'd0, smp_valid}, 32'd0);
    tick(1);
    chk("lat_rom_add1", {24'd0, rom_add}, 32'h11);
    chk("lat_valid1", {31'd0, smp_valid}, 32'd0);
    tick(1);
    chk("lat_valid2", {31'd0, smp_valid}, 32'd1);
    chk("lat_data2", {24'd0, smp_data}, 32'h4A);
    wait_idle(50);
    chk("basic_done", done_cnt - d0, 32'd1);
    chk("basic_count", rx_cnt - rx0, 32'd4);

    // Wrap-around address sequence
    d0 = done_cnt; rx0 = rx_cnt;
    start_run(8'hFE, 8'd4);
    chk("wrap_a0", {24'd0, rom_add}, 32'hFE);
    tick(1); chk("wrap_a1", {24'd0, rom_add}, 32'hFF);
    tick(1); chk("wrap_a2", {24'd0, rom_add}, 32'h00);
    tick(1); chk("wrap_a3", {24'd0, rom_add}, 32'h01);
    wait_idle(50);
    chk("wrap_done", done_cnt - d0, 32'd1);
    chk("wrap_count", rx_cnt - rx0, 32'd4);

    // Table-driven runs
    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Backpressure: FIFO fills, rom_add stalls, no gaps afterwards
    d0 = done_cnt; rx0 = rx_cnt;
    start_run(8'h40, 8'd10);
    for (i = 0; i < 10 && !smp_valid; i++) tick(1);
    smp_ready = 1'b0;
    tick(8);
    chk("bp_rom_add_stall", {24'd0, rom_add}, 32'h44);
    chk("bp_valid", {31'd0, smp_valid}, 32'd1);
    chk("bp_head", {24'd0, smp_data}, 32'h1A);
    smp_ready = 1'b1;
    for (i = 0; i < 40 && exp_q.size() > 0; i++) begin
      chk("bp_no_gap", {31'd0, smp_valid}, 32'd1);
      tick(1);
    end
    wait_idle(50);
    chk("bp_count", rx_cnt - rx0, 32'd10);
    chk("bp_done", done_cnt - d0, 32'd1);

    // Empty run: done two edges after start, no sample
    d0 = done_cnt; rx0 = rx_cnt;
    start = 1'b1; start_addr = 8'h55; length = 8'd0;
    tick(1);
    start = 1'b0;
    chk("empty_busy", {31'd0, busy}, 32'd1);
    chk("empty_done0", {31'd0, done}, 32'd0);
    tick(1);
    chk("empty_done1", {31'd0, done}, 32'd1);
    chk("empty_busy_low", {31'd0, busy}, 32'd0);
    chk("empty_valid", {31'd0, smp_valid}, 32'd0);
    tick(1);
    chk("empty_done2", {31'd0, done}, 32'd0);
    tick(2);
    chk("empty_done_cnt", done_cnt - d0, 32'd1);
    chk("empty_no_sample", rx_cnt - rx0, 32'd0);

    // Start while busy is ignored
    d0 = done_cnt; rx0 = rx_cnt;
    start_run(8'h30, 8'd6);
    tick(2);
    start = 1'b1; start_addr = 8'h80; length = 8'd3;
    tick(1);
    start = 1'b0;
    wait_idle(60);
    chk("busy_start_count", rx_cnt - rx0, 32'd6);
    chk("busy_start_done", done_cnt - d0, 32'd1);

    // Abort in the 5th FETCH cycle
    d0 = done_cnt;
    start_run(8'h60, 8'd20);
    tick(4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    exp_q.delete();
    chk("abort_valid", {31'd0, smp_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rom_add", {24'd0, rom_add}, 32'h64);
    tick(5);
    chk("abort_no_done", done_cnt - d0, 32'd0);
    chk("abort_idle_valid", {31'd0, smp_valid}, 32'd0);
    d0 = done_cnt; rx0 = rx_cnt;
    start_run(8'h00, 8'd2);
    wait_idle(50);
    chk("post_abort_count", rx_cnt - rx0, 32'd2);
    chk("post_abort_done", done_cnt - d0, 32'd1);

    // Asynchronous reset in DRAIN
    start_run(8'h20, 8'd8);
    for (i = 0; i < 30 && rom_add != 8'h28; i++) tick(1);
    chk("drain_reached", {24'd0, rom_add}, 32'h28);
    #2 cen = 1'b0;
    #1;
    chk("arst_rom_add", {24'd0, rom_add}, 32'h0);
    chk("arst_valid", {31'd0, smp_valid}, 32'd0);
    chk("arst_data", {24'd0, smp_data}, 32'h0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    d0 = done_cnt;
    tick(2);
    #2 cen = 1'b1;
    tick(5);
    chk("arst_no_done", done_cnt - d0, 32'd0);
    chk("arst_idle_busy", {31'd0, busy}, 32'd0);
    chk("arst_idle_valid", {31'd0, smp_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
